// File: rtl/ram_pkg.sv
// Shared definitions for the single-port byte RAM bus.
// Holds the default bus widths and the initiator state encoding.
package ram_pkg;

  localparam int unsigned RAM_ADDR_W = 10;
  localparam int unsigned RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StBoot    = 2'd2,
    StBootEnd = 2'd3
  } ram_state_e;

endpackage

// File: rtl/ram_master.sv
// Sole initiator on the single-port byte RAM bus: one-shot CPU accesses plus a
// bootstrap loader that streams bytes into consecutive RAM addresses.
module ram_master
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = RAM_ADDR_W,
  parameter int unsigned DATA_W    = RAM_DATA_W,
  parameter int unsigned BOOT_BASE = 0,
  parameter int unsigned BOOT_LEN  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              boot_start,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_ready,
  output logic              boot_done,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_select,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_bootstrap
);

  localparam int unsigned CNT_W = $clog2(BOOT_LEN + 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BOOT_BASE);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BOOT_LEN - 1);

  ram_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              select_q, select_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    select_d    = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    boot_ready  = 1'b0;
    boot_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A loader start always wins over a same-cycle CPU request.
        req_ready = ~boot_start;
        if (boot_start) begin
          state_d = StBoot;
          cnt_d   = '0;
        end else if (req_valid) begin
          state_d  = StAccess;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          select_d = 1'b1;
          read_d   = ~req_write;
          write_d  = req_write;
        end
      end
      StAccess: begin
        state_d = StIdle;
        if (read_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_data;
        end
      end
      StBoot: begin
        boot_ready = 1'b1;
        if (boot_valid) begin
          select_d = 1'b1;
          write_d  = 1'b1;
          addr_d   = BASE_ADDR + ADDR_W'(cnt_q);
          wdata_d  = boot_data;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = StBootEnd;
          end
        end
      end
      StBootEnd: begin
        // Final loader write is on the bus during this cycle.
        boot_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      select_q    <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      select_q    <= select_d;
      read_q      <= read_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign mem_bootstrap = (state_q == StBoot) || (state_q == StBootEnd);
  assign mem_addr      = addr_q;
  assign mem_select    = select_q;
  assign mem_read      = read_q;
  assign mem_write     = write_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;

  // Only the write cycle drives the shared data bus from this side.
  assign mem_data = write_q ? wdata_q : {DATA_W{1'bz}};

endmodule
